sipo_shift8: RTL and testbench
==============================

SIPO_SHIFT8 -- requirements
Module: sipo_shift8

Interface
REQ-001 Parameter: WIDTH, default 8, number of serial bits per parallel word.
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 RST_L  input  1  reset, asynchronous, active-low.
REQ-004 SIN  input  1  serial data bit, normally the Q of the upstream flip-flop stage.
REQ-005 SEN  input  1  shift enable; SIN is sampled only on edges where SEN=1.
REQ-006 ACK  input  1  consumer acknowledge of the presented word.
REQ-007 PDATA  output  WIDTH  assembled parallel word, MSB = first bit received.
REQ-008 VALID  output  1  PDATA holds an unacknowledged complete word.
REQ-009 OVR  output  1  sticky overrun flag.
REQ-010 BUSY  output  1  a partial word is in the shift register (bit count != 0).

Function
REQ-011 Rising CLK with SEN=1 shall shift: shreg <= {shreg[WIDTH-2:0], SIN}, bit count += 1.
REQ-012 SEN=0 shall hold shreg and bit count unchanged.
REQ-013 Bit count shall run 0..WIDTH-1 and wrap to 0 on the edge capturing bit WIDTH (completion edge).
REQ-014 On a completion edge with VALID=0, PDATA shall load {shreg[WIDTH-2:0], SIN} and VALID shall go 1 on that same edge (zero added latency, visible the cycle after the last bit).
REQ-015 Output FSM states: EMPTY (VALID=0) and FULL (VALID=1); EMPTY->FULL on completion; FULL->EMPTY on ACK=1 with no completion; FULL->FULL otherwise.
REQ-016 ACK=1 on an edge with VALID=0 shall be ignored.
REQ-017 Completion and ACK=1 on the same edge while FULL shall load the new word into PDATA, keep VALID=1, and leave OVR unchanged.
REQ-018 Completion while FULL with ACK=0 shall keep the old PDATA, keep VALID=1, set OVR=1, and discard the new word; shifting shall continue uninterrupted.
REQ-019 OVR shall stay 1 until reset; ACK shall not clear it.
REQ-020 BUSY shall equal (bit count != 0), combinationally.
REQ-021 PDATA shall change only on a completion edge that loads (REQ-014, REQ-017).

Reset
REQ-022 RST_L=0 shall immediately clear shreg, bit count, PDATA (all 0), VALID=0, OVR=0, BUSY=0, and set FSM to EMPTY, independent of CLK.
REQ-023 Reset asserted mid-word shall discard the partial word; the first SEN=1 edge after release shall count as bit 1.
REQ-024 Edges while RST_L=0 shall have no effect; SIN/SEN/ACK shall be ignored.

Structure
REQ-025 A shared package sipo_pkg shall hold the WIDTH default, the bit-count width constant ($clog2(WIDTH)), and the EMPTY/FULL state encoding.
REQ-026 The bit counter shall be one sub-module, bit_cnt, a modulo-WIDTH counter with enable, async active-low clear, and a terminal-count output driving completion.
REQ-027 Shift register, PDATA/VALID/OVR logic, and FSM shall be in sipo_shift8 itself; no other sub-modules.

Verification
REQ-028 Reset, then SEN=1 for 8 edges with SIN=1,0,1,1,0,0,1,0 -> after 8th edge PDATA=8'hB2, VALID=1, OVR=0, BUSY=0; BUSY=1 after edges 1-7.
REQ-029 Same stream with SEN=0 for 3 cycles inserted after bit 4 -> PDATA=8'hB2 after the 8th enabled edge, no change during gaps.
REQ-030 Word 8'hB2 held unacked, second word 8'h5A fully shifted with ACK=0 -> PDATA stays 8'hB2, VALID=1, OVR=1; then ACK=1 -> VALID=0, OVR stays 1.
REQ-031 Word 8'hB2 valid, ACK=1 exactly on completion edge of 8'h0F -> PDATA=8'h0F, VALID=1, OVR=0.
REQ-032 Shift 5 bits, pulse RST_L low for 3 ns between edges -> all outputs 0 immediately; following 8 bits 8'hFF -> PDATA=8'hFF.
REQ-033 ACK=1 with VALID=0 for 4 edges -> VALID, PDATA, OVR unchanged (0).

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared constants and output-state encoding for the serial-to-parallel converter.
package sipo_pkg;

  localparam int SIPO_WIDTH = 8;
  localparam int SIPO_CNT_W = $clog2(SIPO_WIDTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Counter width for any word size; a 1-bit floor keeps degenerate sizes legal.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sipo_shift8_bit_cnt.sv
// Modulo-MOD bit counter with enable and async active-low clear; tc flags the wrap edge.
module bit_cnt #(
  parameter int MOD   = sipo_pkg::SIPO_WIDTH,
  parameter int CNT_W = sipo_pkg::SIPO_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

  // tc is high on the enabled edge that captures the final bit of a word.
  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sipo_shift8.sv
// Serial-in parallel-out converter with a one-word output holding register and sticky overrun.
module sipo_shift8
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_L,
  input  logic             SIN,
  input  logic             SEN,
  input  logic             ACK,
  output logic [WIDTH-1:0] PDATA,
  output logic             VALID,
  output logic             OVR,
  output logic             BUSY
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_next;
  logic [CNT_W-1:0] cnt;
  logic             done;
  state_t           state;

  bit_cnt #(
    .MOD   (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk   (CLK),
    .rst_n (RST_L),
    .en    (SEN),
    .cnt   (cnt),
    .tc    (done)
  );

  // The completing bit is folded in directly so the word is presented with no extra cycle.
  assign word_next = {shreg[WIDTH-2:0], SIN};
  assign BUSY      = (cnt != '0);
  assign VALID     = (state == FULL);

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      shreg <= '0;
      PDATA <= '0;
      OVR   <= 1'b0;
      state <= EMPTY;
    end else begin
      if (SEN) shreg <= word_next;
      case (state)
        EMPTY: begin
          if (done) begin
            PDATA <= word_next;
            state <= FULL;
          end
        end
        FULL: begin
          // A word landing on an unacknowledged one is dropped; the consumer sees OVR.
          if (done && ACK)  PDATA <= word_next;
          else if (done)    OVR   <= 1'b1;
          else if (ACK)     state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_shift8.sv
// Directed bench for sipo_shift8: queue-based reference model, per-cycle compare, literal pins.
module tb_sipo_shift8;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_L = 1'b0;
  logic         SIN = 1'b0;
  logic         SEN = 1'b0;
  logic         ACK = 1'b0;
  logic [W-1:0] PDATA;
  logic         VALID;
  logic         OVR;
  logic         BUSY;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  bit           bits_q[$];
  logic [W-1:0] m_pdata = '0;
  logic         m_valid = 1'b0;
  logic         m_ovr = 1'b0;

  sipo_shift8 #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_L (RST_L),
    .SIN   (SIN),
    .SEN   (SEN),
    .ACK   (ACK),
    .PDATA (PDATA),
    .VALID (VALID),
    .OVR   (OVR),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference model: collect received bits; every W-th bit forms a word, first bit as MSB.
  initial begin
    logic [W-1:0] word;
    bit           done;
    forever begin
      @(posedge CLK or negedge RST_L);
      if (!RST_L) begin
        bits_q.delete();
        m_pdata = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end else begin
        done = 1'b0;
        word = '0;
        if (SEN) begin
          bits_q.push_back(SIN);
          if (bits_q.size() == W) begin
            for (int i = 0; i < W; i++) word = W'(word * 2 + W'(bits_q[i]));
            bits_q.delete();
            done = 1'b1;
          end
        end
        if (done) begin
          if (!m_valid || ACK) begin
            m_pdata = word;
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end else if (ACK && m_valid) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("model_pdata", PDATA, m_pdata);
      chk("model_valid", W'(VALID), W'(m_valid));
      chk("model_ovr",   W'(OVR),   W'(m_ovr));
      chk("model_busy",  W'(BUSY),  W'(bits_q.size() != 0));
    end
  end

  task automatic drive(input logic s, input logic e, input logic a);
    SIN = s;
    SEN = e;
    ACK = a;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic ack_last);
    for (int i = W - 1; i >= 0; i--) drive(w[i], 1'b1, ack_last && (i == 0));
    SEN = 1'b0;
    ACK = 1'b0;
  endtask

  task automatic do_reset();
    RST_L = 1'b0;
    SEN = 1'b0;
    ACK = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_L = 1'b1;
  endtask

  initial begin
    logic [W-1:0] b2;
    b2 = 8'hB2;

    do_reset();
    chk("rst_pdata", PDATA, 8'h00);
    chk("rst_valid", W'(VALID), 8'd0);
    chk("rst_ovr",   W'(OVR),   8'd0);
    chk("rst_busy",  W'(BUSY),  8'd0);
    cmp_en = 1'b1;

    // Basic word 0xB2, BUSY pinned after each of the first seven bits
    for (int i = W - 1; i >= 0; i--) begin
      drive(b2[i], 1'b1, 1'b0);
      if (i > 0) chk("busy_mid", W'(BUSY), 8'd1);
    end
    SEN = 1'b0;
    chk("w1_pdata", PDATA, 8'hB2);
    chk("w1_valid", W'(VALID), 8'd1);
    chk("w1_ovr",   W'(OVR),   8'd0);
    chk("w1_busy",  W'(BUSY),  8'd0);
    drive(1'b0, 1'b0, 1'b1);
    chk("ack_valid", W'(VALID), 8'd0);

    // Same stream with a 3-cycle SEN gap after bit 4
    for (int i = W - 1; i >= 4; i--) drive(b2[i], 1'b1, 1'b0);
    repeat (3) begin
      drive(1'b1, 1'b0, 1'b0);
      chk("gap_pdata", PDATA, 8'hB2);
      chk("gap_busy",  W'(BUSY), 8'd1);
    end
    for (int i = 3; i >= 0; i--) drive(b2[i], 1'b1, 1'b0);
    SEN = 1'b0;
    chk("gap_word", PDATA, 8'hB2);
    chk("gap_valid", W'(VALID), 8'd1);

    // Overrun: 0x5A arrives while 0xB2 is unacknowledged
    send_word(8'h5A, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("ovr_pdata", PDATA, 8'hB2);
    chk("ovr_valid", W'(VALID), 8'd1);
    chk("ovr_flag",  W'(OVR),   8'd1);
    drive(1'b0, 1'b0, 1'b1);
    chk("ovr_ack_valid", W'(VALID), 8'd0);
    chk("ovr_sticky",    W'(OVR),   8'd1);

    // Completion coinciding with ACK replaces the word without overrun
    do_reset();
    send_word(8'hB2, 1'b0);
    send_word(8'h0F, 1'b1);
    chk("ackc_pdata", PDATA, 8'h0F);
    chk("ackc_valid", W'(VALID), 8'd1);
    chk("ackc_ovr",   W'(OVR),   8'd0);

    // Async reset mid-word, then a fresh 0xFF
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
    SEN = 1'b0;
    RST_L = 1'b0;
    #1;
    chk("arst_pdata", PDATA, 8'h00);
    chk("arst_valid", W'(VALID), 8'd0);
    chk("arst_ovr",   W'(OVR),   8'd0);
    chk("arst_busy",  W'(BUSY),  8'd0);
    #2;
    RST_L = 1'b1;
    send_word(8'hFF, 1'b0);
    chk("ff_pdata", PDATA, 8'hFF);
    chk("ff_valid", W'(VALID), 8'd1);

    // ACK while empty is ignored
    do_reset();
    repeat (4) drive(1'b0, 1'b0, 1'b1);
    ACK = 1'b0;
    chk("idle_ack_valid", W'(VALID), 8'd0);
    chk("idle_ack_pdata", PDATA, 8'h00);
    chk("idle_ack_ovr",   W'(OVR),   8'd0);

    repeat (2) @(posedge CLK);
    cmp_en = 1'b0;
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
